// File: rtl/tc_sampler_pkg.sv
// rtl/tc_sampler_pkg.sv - shared types, frame field positions and widths for the thermocouple sampler
package tc_sampler_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    localparam int TC_MSB    = 31;
    localparam int TC_LSB    = 18;
    localparam int FAULT_BIT = 16;
    localparam int JT_MSB    = 15;
    localparam int JT_LSB    = 4;

    localparam int TC_W  = 14;
    localparam int JT_W  = 12;
    localparam int FLT_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/multi_thermocouple_sampler_if.sv
// rtl/multi_thermocouple_sampler_if.sv - request/response handshake between the sampler and the shared SPI master
interface multi_thermocouple_sampler_if #(
    parameter int SW = 2
);
    logic          spi_not_busy;
    logic [31:0]   spi_rx_data;
    logic          spi_ena;
    logic [SW-1:0] spi_sel;

    // master: the sampler side that issues requests; slave: the SPI engine that serves them
    modport master (
        input  spi_not_busy,
        input  spi_rx_data,
        output spi_ena,
        output spi_sel
    );

    modport slave (
        output spi_not_busy,
        output spi_rx_data,
        input  spi_ena,
        input  spi_sel
    );
endinterface

// File: rtl/tc_frame_decode.sv
// rtl/tc_frame_decode.sv - slices a 32-bit converter frame into temperature, junction and fault fields
module tc_frame_decode
    import tc_sampler_pkg::*;
(
    input  logic [31:0]      frame_i,
    output logic [TC_W-1:0]  tc_o,
    output logic [JT_W-1:0]  jt_o,
    output logic [FLT_W-1:0] fault_o
);

    assign tc_o    = frame_i[TC_MSB:TC_LSB];
    assign jt_o    = frame_i[JT_MSB:JT_LSB];
    assign fault_o = {frame_i[FAULT_BIT], frame_i[2:0]};

endmodule

// File: rtl/multi_thermocouple_sampler.sv
// rtl/multi_thermocouple_sampler.sv - round-robin sampler of N_CH thermocouple converters over one SPI master
module multi_thermocouple_sampler
    import tc_sampler_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int STARTUP_CYCLES = 144000,
    parameter int GAP_CYCLES     = 48000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CW             = $clog2(max3(STARTUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1),
    parameter int SW             = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_thermocouple_sampler_if.master spi,
    output logic [TC_W*N_CH-1:0]   tc_temp_data,
    output logic [JT_W*N_CH-1:0]   junction_temp_data,
    output logic [FLT_W*N_CH-1:0]  fault_bits,
    output logic [N_CH-1:0]        timeout_flags,
    output logic                   sample_valid,
    output logic [SW-1:0]          sample_ch,
    output logic                   any_fault
);

    state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ch_q, ch_d;
    logic    spi_ena_q, spi_ena_d;
    logic    capture, timeout_evt;

    logic [TC_W*N_CH-1:0]  tc_q;
    logic [JT_W*N_CH-1:0]  jt_q;
    logic [FLT_W*N_CH-1:0] flt_q;
    logic [N_CH-1:0]       to_q;
    logic                  sv_q;
    logic [SW-1:0]         sch_q;
    logic                  af_q;

    logic [TC_W-1:0]  dec_tc;
    logic [JT_W-1:0]  dec_jt;
    logic [FLT_W-1:0] dec_flt;

    tc_frame_decode u_decode (
        .frame_i (spi.spi_rx_data),
        .tc_o    (dec_tc),
        .jt_o    (dec_jt),
        .fault_o (dec_flt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            ch_q      <= '0;
            spi_ena_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            spi_ena_q <= spi_ena_d;
        end
    end

    // cnt restarts on every transition; the handshake outranks the REQ timeout
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        ch_d        = ch_q;
        spi_ena_d   = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    ch_d    = '0;
                end
            end
            ST_REQ: begin
                if (!spi.spi_not_busy) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                end else begin
                    spi_ena_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (spi.spi_not_busy) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    ch_d    = (ch_q == SW'(N_CH - 1)) ? '0 : ch_q + SW'(1);
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_REQ;
                cnt_d   = '0;
            end
        endcase
    end

    // per-channel register file: only the slot addressed by ch is touched
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q  <= '0;
            jt_q  <= '0;
            flt_q <= '0;
            to_q  <= '0;
            sv_q  <= 1'b0;
            sch_q <= '0;
            af_q  <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_q == SW'(k)) begin
                    if (capture) begin
                        tc_q[k*TC_W +: TC_W]    <= dec_tc;
                        jt_q[k*JT_W +: JT_W]    <= dec_jt;
                        flt_q[k*FLT_W +: FLT_W] <= dec_flt;
                        to_q[k]                 <= 1'b0;
                    end else if (timeout_evt) begin
                        to_q[k] <= 1'b1;
                    end
                end
            end
            sv_q <= capture;
            if (capture) begin
                sch_q <= ch_q;
            end
            af_q <= (|flt_q) | (|to_q);
        end
    end

    assign spi.spi_ena         = spi_ena_q;
    assign spi.spi_sel         = ch_q;
    assign tc_temp_data        = tc_q;
    assign junction_temp_data  = jt_q;
    assign fault_bits          = flt_q;
    assign timeout_flags       = to_q;
    assign sample_valid        = sv_q;
    assign sample_ch           = sch_q;
    assign any_fault           = af_q;

endmodule
